// File: rtl/rpm_multiplier.sv
// Russian-peasant (shift-and-add) multiplier.
// x is the multiplier, halved each iteration. y is the multiplicand, doubled
// each iteration. Whenever x is odd, y is added into acc.
// The operation finishes on the RUN cycle where x has dropped to 0 or 1.
//
// state | meaning
// IDLE  | waiting for start; product/iter_cnt hold the last result
// RUN   | one shift-and-add iteration per cycle
// DONE  | one-cycle completion pulse; start here chains a new operation
module rpm_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [CNT_W-1:0]     iter_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   x;
  logic [2*WIDTH-1:0] y;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic [2*WIDTH-1:0] acc_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               last_iter;

  // Next accumulator/count for the current iteration; x <= 1 ends the run.
  always_comb begin
    acc_n     = acc + (x[0] ? y : '0);
    cnt_n     = cnt + CNT_W'(1);
    last_iter = (x[WIDTH-1:1] == '0);
  end

  // Status outputs decode directly from the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Sequencer and datapath registers; reset overrides everything including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      acc      <= '0;
      cnt      <= '0;
      product  <= '0;
      iter_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x     <= a;
            y     <= {{WIDTH{1'b0}}, b};
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (last_iter) begin
            product  <= acc_n;
            iter_cnt <= cnt_n;
            state    <= DONE;
          end else begin
            x     <= x >> 1;
            y     <= y << 1;
            acc   <= acc_n;
            cnt   <= cnt_n;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpm_multiplier.sv
// Self-checking bench for rpm_multiplier (WIDTH=32): directed vector table,
// hand-written back-to-back and reset-abort sequences, then random operations.
module tb_rpm_multiplier;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [CNT_W-1:0]     iter_cnt;

  rpm_multiplier #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .iter_cnt (iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*WIDTH-1:0] prod;
    int                 cnt;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0]   va;
    logic [WIDTH-1:0]   vb;
    logic [2*WIDTH-1:0] prod;
    int                 lat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [2*WIDTH-1:0] act,
                     input logic [2*WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int ref_lat(input logic [WIDTH-1:0] v);
    int msb = 0;
    if (v <= 1) return 1;
    for (int i = 0; i < WIDTH; i++) if (v[i]) msb = i;
    return msb + 1;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending result.
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", product, e.prod);
        chk("iter_cnt", 64'(iter_cnt), 64'(e.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation and check latency, busy window and hold-after-done.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                        input logic [2*WIDTH-1:0] exp_p, input int exp_l);
    exp_t e;
    int n;
    e.prod = exp_p;
    e.cnt  = exp_l;
    sb.push_back(e);
    start = 1'b1;
    a     = ta;
    b     = tb_b;
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    n = 0;
    while (!done && n <= WIDTH + 2) begin
      if (n >= 1) chk("busy_in_run", 64'(busy), 1);
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(exp_l));
    chk("busy_at_done", 64'(busy), 0);
    tick();
    chk("done_one_cycle", 64'(done), 0);
    chk("product_hold", product, exp_p);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'd13,        32'd11,        64'd143,                 4};
    vecs[1] = '{32'd0,         32'hDEADBEEF,  64'd0,                   1};
    vecs[2] = '{32'd1,         32'hDEADBEEF,  64'h00000000DEADBEEF,    1};
    vecs[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE00000001,    32};
    vecs[4] = '{32'd1000,      32'd0,         64'd0,                   10};
    vecs[5] = '{32'h80000000,  32'd3,         64'h0000000180000000,    32};

    rst   = 1'b1;
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd9;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_product", product, 0);
    chk("rst_iter_cnt", 64'(iter_cnt), 0);

    // First start coincides with the first edge where rst is low.
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].prod, vecs[i].lat);

    // Start held high during RUN is ignored; then chain a new op from DONE.
    begin
      exp_t e;
      e.prod = 64'd42; e.cnt = 3; sb.push_back(e);
      start = 1'b1; a = 32'd6; b = 32'd7;
      tick();                         // edge k accepted
      a = 32'd100;                    // start still high at k+1, k+2
      tick();
      chk("b2b_busy_k1", 64'(busy), 1);
      tick();
      chk("b2b_busy_k2", 64'(busy), 1);
      start = 1'b0;
      tick();                         // edge k+3
      chk("b2b_done_k3", 64'(done), 1);
      chk("b2b_first_product", product, 64'd42);
      e.prod = 64'd25; e.cnt = 3; sb.push_back(e);
      start = 1'b1; a = 32'd5; b = 32'd5;
      tick();                         // edge k+4 accepts during done
      start = 1'b0;
      chk("b2b_restart_busy", 64'(busy), 1);
      tick();
      tick();
      chk("b2b_second_not_done", 64'(done), 0);
      tick();                         // edge k+7
      chk("b2b_second_done", 64'(done), 1);
      chk("b2b_second_product", product, 64'd25);
      tick();
    end

    // Reset mid-operation aborts with no done pulse.
    start = 1'b1; a = 32'h80000000; b = 32'd3;
    tick();                           // edge k
    start = 1'b0;
    repeat (9) tick();                // edge k+9
    chk("abort_busy_before", 64'(busy), 1);
    rst = 1'b1;
    tick();                           // edge k+10
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_product", product, 0);
    chk("abort_iter_cnt", 64'(iter_cnt), 0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (done || busy) seen++;
      end
      chk("abort_no_activity", 64'(seen), 0);
    end

    // Random operands; shifting a keeps the mix of latencies broad.
    for (int i = 0; i < 2000; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom;
      if (i % 7 == 0) rb = rb >> $urandom_range(0, 31);
      run_op(ra, rb, 64'(ra) * 64'(rb), ref_lat(ra));
    end

    repeat (3) tick();
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
